// File: rtl/label_text_ctrl.sv
// Label overlay text controller: shadow/active character buffers swapped at frame
// start, a three-stage font ROM fetch pipeline, and optional frame-based blinking.
module label_text_ctrl #(
   parameter int         BLINK_FRAMES = 0,
   parameter logic [7:0] INIT_CHAR    = 8'h20
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        vs,
   input  logic        in_label,
   input  logic [2:0]  place,
   input  logic [2:0]  row,
   input  logic [2:0]  pixel,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [7:0]  wr_char,
   input  logic        commit,
   output logic        pending,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        pix_on,
   output logic        pix_valid
);

   logic [7:0]  r_shadow [8];
   logic [7:0]  r_active [8];
   logic        r_vs_d;
   logic        r_pending;
   logic [10:0] r_rom_addr;
   logic [2:0]  r_pix_d1, r_pix_d2;
   logic        r_lab_d1, r_lab_d2;
   logic        r_pix_on, r_pix_valid;
   logic        w_frame_start;
   logic        w_swap;
   logic        w_visible;

   assign w_frame_start = vs & ~r_vs_d;
   // A commit arriving on the frame-start cycle itself is served immediately.
   assign w_swap        = w_frame_start & (r_pending | commit);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vs_d    <= 1'b0;
         r_pending <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_shadow[i] <= INIT_CHAR;
            r_active[i] <= INIT_CHAR;
         end
      end else begin
         r_vs_d <= vs;
         if (wr_en)
            r_shadow[wr_addr] <= wr_char;
         if (w_swap) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
         end else if (commit) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rom_addr  <= {INIT_CHAR, 3'd0};
         r_pix_d1    <= 3'd0;
         r_pix_d2    <= 3'd0;
         r_lab_d1    <= 1'b0;
         r_lab_d2    <= 1'b0;
         r_pix_on    <= 1'b0;
         r_pix_valid <= 1'b0;
      end else begin
         r_rom_addr  <= {r_active[place], row};
         r_pix_d1    <= pixel;
         r_lab_d1    <= in_label;
         r_pix_d2    <= r_pix_d1;
         r_lab_d2    <= r_lab_d1;
         // Glyph bit 7 is the leftmost column.
         r_pix_on    <= r_lab_d2 & w_visible & rom_data[3'd7 - r_pix_d2];
         r_pix_valid <= r_lab_d2;
      end
   end

   generate
      if (BLINK_FRAMES > 0) begin : g_blink
         localparam int CW = $clog2(BLINK_FRAMES + 1);
         logic [CW-1:0] r_frm_cnt;
         logic          r_visible;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_frm_cnt <= '0;
               r_visible <= 1'b1;
            end else if (w_frame_start) begin
               if (r_frm_cnt == CW'(BLINK_FRAMES - 1)) begin
                  r_frm_cnt <= '0;
                  r_visible <= ~r_visible;
               end else begin
                  r_frm_cnt <= r_frm_cnt + CW'(1);
               end
            end
         end
         assign w_visible = r_visible;
      end else begin : g_no_blink
         assign w_visible = 1'b1;
      end
   endgenerate

   assign pending   = r_pending;
   assign rom_addr  = r_rom_addr;
   assign pix_on    = r_pix_on;
   assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_label_text_ctrl.sv
// Directed bench for label_text_ctrl: scoreboarded pixel pipeline, buffer swap
// corner cases, mid-frame reset and a second instance exercising blinking.
module tb_label_text_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        vs = 1'b0;
   logic        in_label = 1'b0;
   logic [2:0]  place = 3'd0, row = 3'd0, pixel = 3'd0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [7:0]  wr_char = 8'h00;
   logic        commit = 1'b0;
   logic        pending, pix_on, pix_valid;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data = 8'h00;
   logic        b_pending, b_pix_on, b_pix_valid;
   logic [10:0] b_rom_addr;
   logic [7:0]  b_rom_data = 8'h00;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct { int due; logic v; logic on; } exp_t;
   exp_t sb[$];

   logic [7:0] m_shadow [8];
   logic [7:0] m_active [8];
   logic       m_pending;

   label_text_ctrl u_dut (
      .clk(clk), .rstn(rstn), .vs(vs), .in_label(in_label), .place(place), .row(row),
      .pixel(pixel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .commit(commit),
      .pending(pending), .rom_addr(rom_addr), .rom_data(rom_data), .pix_on(pix_on),
      .pix_valid(pix_valid)
   );

   label_text_ctrl #(.BLINK_FRAMES(2), .INIT_CHAR(8'h41)) u_blk (
      .clk(clk), .rstn(rstn), .vs(vs), .in_label(in_label), .place(place), .row(row),
      .pixel(pixel), .wr_en(1'b0), .wr_addr(3'd0), .wr_char(8'h00), .commit(1'b0),
      .pending(b_pending), .rom_addr(b_rom_addr), .rom_data(b_rom_data), .pix_on(b_pix_on),
      .pix_valid(b_pix_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Font model: space is blank, 'G' row 3 is 8'b1000_0001, others an asymmetric pattern.
   function automatic logic [7:0] font(input logic [10:0] a);
      logic [7:0] c;
      logic [2:0] r;
      c = a[10:3];
      r = a[2:0];
      if (c == 8'h20) return 8'h00;
      if (c == 8'h47 && r == 3'd3) return 8'h81;
      return c ^ {r, 5'b10101};
   endfunction

   always @(posedge clk) begin
      rom_data   <= font(rom_addr);
      b_rom_data <= font(b_rom_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("pix_valid", {31'd0, pix_valid}, {31'd0, e.v});
         chk("pix_on", {31'd0, pix_on}, {31'd0, e.on});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic il, input logic [2:0] p, input logic [2:0] r, input logic [2:0] x);
      exp_t e;
      logic [7:0] f;
      in_label = il; place = p; row = r; pixel = x;
      f = font({m_active[p], r});
      e.due = cyc + 3;
      e.v = il;
      e.on = il & f[3'd7 - x];
      sb.push_back(e);
      tick();
   endtask

   task automatic pix_row(input logic [2:0] p, input logic [2:0] r);
      for (int x = 0; x < 8; x++) pix(1'b1, p, r, x[2:0]);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] c);
      wr_en = 1'b1; wr_addr = a; wr_char = c;
      tick();
      wr_en = 1'b0;
      m_shadow[a] = c;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      m_pending = 1'b1;
   endtask

   task automatic vs_rise();
      vs = 1'b1;
      tick();
      if (m_pending) begin
         m_active = m_shadow;
         m_pending = 1'b0;
      end
      vs = 1'b0;
      tick();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = 8'h20;
         m_active[i] = 8'h20;
      end
      m_pending = 1'b0;
   endtask

   int pat [6] = '{1, 1, 0, 0, 1, 1};
   byte txt [8] = '{8'h47, 8'h4F, 8'h57, 8'h49, 8'h4E, 8'h4E, 8'h50, 8'h55};

   initial begin
      model_reset();
      repeat (3) tick();
      chk("rst_pending", {31'd0, pending}, 0);
      chk("rst_pix_on", {31'd0, pix_on}, 0);
      chk("rst_pix_valid", {31'd0, pix_valid}, 0);
      chk("rst_rom_addr", {21'd0, rom_addr}, 32'h100);
      rstn = 1'b1;
      tick();

      // Idle video over the space glyph.
      pix_row(3'd0, 3'd0);
      chk("idle_rom_addr", {21'd0, rom_addr}, 32'h100);

      for (int i = 0; i < 8; i++) wr(i[2:0], txt[i]);
      do_commit();
      chk("commit_pending", {31'd0, pending}, 1);
      pix_row(3'd0, 3'd3);
      chk("pre_swap_rom_addr", {21'd0, rom_addr}, 32'h103);
      chk("pre_swap_pending", {31'd0, pending}, 1);

      vs = 1'b1;
      tick();
      m_active = m_shadow;
      m_pending = 1'b0;
      chk("swap_pending_clear", {31'd0, pending}, 0);
      vs = 1'b0;
      tick();
      pix_row(3'd0, 3'd3);
      chk("swap_rom_addr_G", {21'd0, rom_addr}, {21'd0, 8'h47, 3'd3});
      pix_row(3'd4, 3'd1);
      pix_row(3'd7, 3'd6);

      // Write to shadow on the same cycle as a pending swap.
      wr(3'd2, 8'h5A);
      do_commit();
      vs = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_char = 8'h58;
      tick();
      m_active = m_shadow;
      m_shadow[2] = 8'h58;
      m_pending = 1'b0;
      vs = 1'b0; wr_en = 1'b0;
      chk("wr_at_fs_pending", {31'd0, pending}, 0);
      tick();
      pix_row(3'd2, 3'd0);
      chk("wr_at_fs_active", {21'd0, rom_addr}, {21'd0, 8'h5A, 3'd0});
      do_commit();
      vs_rise();
      pix_row(3'd2, 3'd0);
      chk("wr_at_fs_shadow", {21'd0, rom_addr}, {21'd0, 8'h58, 3'd0});

      // Commit coinciding with frame start, pending clear.
      wr(3'd5, 8'h33);
      vs = 1'b1; commit = 1'b1;
      tick();
      m_active = m_shadow;
      vs = 1'b0; commit = 1'b0;
      chk("commit_fs_p0_pending", {31'd0, pending}, 0);
      tick();
      pix_row(3'd5, 3'd2);
      chk("commit_fs_p0_swap", {21'd0, rom_addr}, {21'd0, 8'h33, 3'd2});

      // Commit coinciding with frame start, pending set.
      wr(3'd6, 8'h44);
      do_commit();
      chk("commit_fs_p1_pre", {31'd0, pending}, 1);
      vs = 1'b1; commit = 1'b1;
      tick();
      m_active = m_shadow;
      m_pending = 1'b0;
      vs = 1'b0; commit = 1'b0;
      chk("commit_fs_p1_pending", {31'd0, pending}, 0);
      tick();
      chk("commit_fs_p1_stays", {31'd0, pending}, 0);
      pix_row(3'd6, 3'd7);
      chk("commit_fs_p1_swap", {21'd0, rom_addr}, {21'd0, 8'h44, 3'd7});

      // Leaving the label area on a lit glyph pixel.
      for (int i = 0; i < 3; i++) pix(1'b1, 3'd0, 3'd3, 3'd0);
      for (int i = 0; i < 3; i++) pix(1'b0, 3'd0, 3'd3, 3'd0);
      pix(1'b1, 3'd0, 3'd3, 3'd7);
      pix(1'b0, 3'd0, 3'd3, 3'd7);
      repeat (4) tick();
      chk("sb_drained", sb.size(), 0);

      // Mid-frame reset with a commit outstanding.
      in_label = 1'b1; place = 3'd0; row = 3'd3; pixel = 3'd0;
      repeat (4) tick();
      chk("pre_rst_pix_on", {31'd0, pix_on}, 1);
      do_commit();
      chk("pre_rst_pending", {31'd0, pending}, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_rst_pix_on", {31'd0, pix_on}, 0);
      chk("async_rst_pending", {31'd0, pending}, 0);
      model_reset();
      tick();
      tick();
      rstn = 1'b1;

      // Blink instance starts at frame 0 after reset release.
      in_label = 1'b1; place = 3'd0; row = 3'd0; pixel = 3'd1;
      repeat (4) tick();
      chk("blink_f0", {31'd0, b_pix_on}, pat[0]);
      chk("post_rst_rom_addr", {21'd0, rom_addr}, 32'h100);
      for (int f = 1; f < 6; f++) begin
         vs_rise();
         repeat (4) tick();
         chk($sformatf("blink_f%0d", f), {31'd0, b_pix_on}, pat[f]);
         chk("no_swap_rom_addr", {21'd0, rom_addr}, 32'h100);
         chk("no_swap_pending", {31'd0, pending}, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
